// File: rtl/timer_sched_pkg.sv
// Shared constants and state encoding for the timer scheduler.
// Register map and control words of the interval-timer slave it drives.
package timer_sched_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam logic [15:0] CTL_START_ITO = 16'h0005;
  localparam logic [15:0] CTL_STOP      = 16'h0008;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_WAIT_IRQ,
    S_WR_STOP,
    S_WR_STAT,
    S_DONE
  } state_e;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// wrapping around; purely combinational.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             gnt_valid,
  output logic [2:0]       gnt_idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [3:0]         idx_sum;

  // Doubling the vector lets a plain shift implement the wrap-around rotation.
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> ptr);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_valid = 1'b1;
        idx_sum   = {1'b0, ptr} + 4'(k);
        if (idx_sum >= 4'(N_REQ)) begin
          idx_sum = idx_sum - 4'(N_REQ);
        end
        gnt_idx = idx_sum[2:0];
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Shares one interval timer between N_REQ requesters: grants round-robin,
// programs a one-shot delay over a write-only Avalon master and pulses done.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_period,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [2:0]            active_id,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  state_e           state_q, state_d;
  logic [2:0]       active_id_q, active_id_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [31:0]      period_q, period_d;
  logic             abort_q, abort_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             wn_q, wn_d;
  logic [2:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;

  logic             gnt_valid;
  logic [2:0]       gnt_idx;
  logic [7:0]       req_ext;
  logic [31:0]      period_arr [8];

  assign req_ext = 8'(req);

  for (genvar i = 0; i < 8; i++) begin : g_period
    if (i < N_REQ) begin : g_used
      assign period_arr[i] = req_period[32*i +: 32];
    end else begin : g_unused
      assign period_arr[i] = '0;
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    ptr_d       = ptr_q;
    period_d    = period_q;
    abort_d     = abort_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          active_id_d = gnt_idx;
          period_d    = period_arr[gnt_idx];
          abort_d     = 1'b0;
          // A zero period never produces a timeout, so skip the timer entirely.
          state_d     = (period_d == 32'd0) ? S_DONE : S_WR_PL;
        end
      end
      S_WR_PL:  state_d = S_WR_PH;
      S_WR_PH:  state_d = S_WR_CTL;
      S_WR_CTL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (tmr_irq) begin
          state_d = S_WR_STAT;
        end else if (!req_ext[active_id_q]) begin
          state_d = S_WR_STOP;
          abort_d = 1'b1;
        end
      end
      S_WR_STOP: state_d = S_WR_STAT;
      S_WR_STAT: state_d = abort_q ? S_IDLE : S_DONE;
      S_DONE: begin
        ptr_d   = (active_id_q == 3'(N_REQ - 1)) ? 3'd0 : active_id_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    busy_d  = (state_d != S_IDLE);
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = ADDR_STATUS;
    wdata_d = '0;
    case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wdata_d = period_d[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wdata_d = period_d[31:16];
      end
      S_WR_CTL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTL_START_ITO;
      end
      S_WR_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTL_STOP;
      end
      S_WR_STAT: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; wdata_d = 16'h0000;
      end
      default: ;
    endcase

    done_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      done_d[i] = (state_d == S_DONE) && (active_id_d == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      active_id_q <= '0;
      ptr_q       <= '0;
      period_q    <= '0;
      abort_q     <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      ptr_q       <= ptr_d;
      period_q    <= period_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign done           = done_q;
  assign busy           = busy_q;
  assign active_id      = active_id_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: a behavioural timer model answers the bus,
// and a scoreboard queue of expected bus writes / done pulses is checked in order.
module tb_timer_sched;

  localparam int N = 4;
  localparam int EV_NONE = 0, EV_WR = 1, EV_DONE = 2;
  localparam int GAP_ANY = -1, GAP_IRQ = -2, GAP_MARK = -3;

  typedef struct {
    int         kind;
    logic [2:0] addr;
    logic [15:0] data;
    logic [3:0] dvec;
    int         gap;
  } ev_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [32*N-1:0] req_period;
  logic [N-1:0]   done;
  logic           busy;
  logic [2:0]     active_id;
  logic [2:0]     tmr_address;
  logic           tmr_chipselect;
  logic           tmr_write_n;
  logic [15:0]    tmr_writedata;
  logic           tmr_irq;

  ev_t  exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   mark_cyc = 0;
  int   last_cyc = 0;
  int   irq_cyc = 0;

  logic [31:0] m_period;
  int          m_cnt;
  bit          m_run;

  timer_sched #(.N_REQ(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_period     (req_period),
    .done           (done),
    .busy           (busy),
    .active_id      (active_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Timer model: period write stops the counter, START arms it, status write clears irq.
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: tmr_irq = 1'b0;
        3'd1: begin
          if (tmr_writedata[3]) m_run = 1'b0;
          if (tmr_writedata[2]) begin m_run = 1'b1; m_cnt = int'(m_period) + 1; end
        end
        3'd2: begin m_period[15:0] = tmr_writedata; m_run = 1'b0; end
        3'd3: begin m_period[31:16] = tmr_writedata; m_run = 1'b0; end
        default: ;
      endcase
    end else if (m_run) begin
      if (m_cnt == 0) begin
        tmr_irq = 1'b1; m_run = 1'b0; irq_cyc = cyc;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  task automatic score(input int kind, input logic [2:0] addr, input logic [15:0] data,
                       input logic [3:0] dvec);
    ev_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{EV_NONE, 3'd0, 16'd0, 4'd0, GAP_ANY};
    checkOutput("sb_kind", 32'(kind), 32'(e.kind));
    if (kind == EV_WR) begin
      checkOutput("sb_addr", 32'(addr), 32'(e.addr));
      checkOutput("sb_data", 32'(data), 32'(e.data));
      checkOutput("sb_write_n", 32'(tmr_write_n), 32'd0);
    end else begin
      checkOutput("sb_done_vec", 32'(dvec), 32'(e.dvec));
    end
    if (e.gap >= 0)            checkOutput("sb_gap", 32'(cyc - last_cyc), 32'(e.gap));
    else if (e.gap == GAP_IRQ)  checkOutput("sb_irq_latency", 32'(cyc - irq_cyc), 32'd1);
    else if (e.gap == GAP_MARK) checkOutput("sb_req_latency", 32'(cyc - mark_cyc), 32'd1);
    last_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (tmr_chipselect) score(EV_WR, tmr_address, tmr_writedata, 4'd0);
    if (done != '0)     score(EV_DONE, 3'd0, 16'd0, done);
  end

  task automatic pushEv(input int kind, input logic [2:0] a, input logic [15:0] d,
                        input logic [3:0] v, input int g);
    exp_q.push_back('{kind, a, d, v, g});
  endtask

  task automatic pushGrant(input int id, input logic [31:0] p, input bit first);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    if (p == 32'd0) begin
      pushEv(EV_DONE, 3'd0, 16'd0, oh, first ? GAP_MARK : 2);
    end else begin
      pushEv(EV_WR, 3'd2, p[15:0], 4'd0, first ? GAP_MARK : 2);
      pushEv(EV_WR, 3'd3, p[31:16], 4'd0, 1);
      pushEv(EV_WR, 3'd1, 16'h0005, 4'd0, 1);
      pushEv(EV_WR, 3'd0, 16'h0000, 4'd0, GAP_IRQ);
      pushEv(EV_DONE, 3'd0, 16'd0, oh, 1);
    end
  endtask

  task automatic pushAbort(input logic [31:0] p);
    pushEv(EV_WR, 3'd2, p[15:0], 4'd0, GAP_MARK);
    pushEv(EV_WR, 3'd3, p[31:16], 4'd0, 1);
    pushEv(EV_WR, 3'd1, 16'h0005, 4'd0, 1);
    pushEv(EV_WR, 3'd1, 16'h0008, 4'd0, GAP_MARK);
    pushEv(EV_WR, 3'd0, 16'h0000, 4'd0, 1);
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] p);
    req_period[32*id +: 32] = p;
    req[id] = 1'b1;
    mark_cyc = cyc;
  endtask

  task automatic dropReq(input int id);
    req[id] = 1'b0;
    mark_cyc = cyc;
  endtask

  task automatic waitDone(input int budget, input bit chk_busy);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done != '0) seen = 1'b1;
      else if (chk_busy) checkOutput("busy_during_service", 32'(busy), 32'd1);
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic waitWrite(input logic [2:0] addr, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (tmr_chipselect && tmr_address == addr) seen = 1'b1;
    end
    checkOutput("write_seen", 32'(seen), 32'd1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_active_id", 32'(active_id), 32'd0);
    checkOutput("rst_chipselect", 32'(tmr_chipselect), 32'd0);
    checkOutput("rst_write_n", 32'(tmr_write_n), 32'd1);
    checkOutput("rst_address", 32'(tmr_address), 32'd0);
    checkOutput("rst_writedata", 32'(tmr_writedata), 32'd0);
  endtask

  initial begin
    bit found;
    int n;
    reset = 1'b1; req = '0; req_period = '0; tmr_irq = 1'b0;
    m_period = '0; m_cnt = 0; m_run = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkResetValues();
    reset = 1'b0;

    $display("[TB] single request, period 100");
    pushGrant(1, 32'd100, 1'b1);
    applyStimulus(1, 32'd100);
    @(negedge clk); #1;
    checkOutput("t1_active_id", 32'(active_id), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitDone(300, 1'b1);
    checkOutput("t1_done_vec", 32'(done), 32'h2);
    dropReq(1);
    @(negedge clk); #1;
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    checkOutput("t1_done_cleared", 32'(done), 32'd0);
    checkOutput("t1_active_id_hold", 32'(active_id), 32'd1);
    checkOutput("t1_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] round robin with all four requesting");
    reset = 1'b1; @(negedge clk); #1; reset = 1'b0;
    pushGrant(0, 32'd20, 1'b1);
    pushGrant(1, 32'd20, 1'b0);
    pushGrant(2, 32'd20, 1'b0);
    pushGrant(3, 32'd20, 1'b0);
    pushGrant(0, 32'd20, 1'b0);
    for (int i = 0; i < N; i++) applyStimulus(i, 32'd20);
    n = 0;
    for (int i = 0; i < 2000 && n < 5; i++) begin
      @(negedge clk); #1;
      if (done != '0) n = n + 1;
    end
    req = '0;
    checkOutput("t2_grant_count", 32'(n), 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("t2_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] wide period split and latching, then zero period");
    pushAbort(32'h0001_2345);
    applyStimulus(0, 32'h0001_2345);
    waitWrite(3'd2, 5);
    req_period[31:0] = 32'hFFFF_FFFF;
    waitWrite(3'd1, 5);
    repeat (3) @(negedge clk);
    #1 dropReq(0);
    waitWrite(3'd0, 10);
    @(negedge clk); #1;
    checkOutput("t3_busy_after_abort", 32'(busy), 32'd0);
    checkOutput("t3_no_done", 32'(done), 32'd0);
    pushGrant(3, 32'd0, 1'b1);
    applyStimulus(3, 32'd0);
    @(negedge clk); #1;
    checkOutput("t3_p0_done", 32'(done), 32'h8);
    checkOutput("t3_p0_no_cs", 32'(tmr_chipselect), 32'd0);
    dropReq(3);
    repeat (2) @(negedge clk);
    checkOutput("t3_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] abort keeps priority");
    pushAbort(32'd100);
    applyStimulus(2, 32'd100);
    waitWrite(3'd1, 5);
    repeat (5) @(negedge clk);
    #1 dropReq(2);
    waitWrite(3'd0, 10);
    @(negedge clk); #1;
    checkOutput("t4_no_done", 32'(done), 32'd0);
    checkOutput("t4_busy_idle", 32'(busy), 32'd0);
    pushGrant(2, 32'd0, 1'b1);
    pushGrant(3, 32'd0, 1'b0);
    applyStimulus(3, 32'd0);
    applyStimulus(2, 32'd0);
    waitDone(10, 1'b0);
    checkOutput("t4_regrant_2", 32'(done), 32'h4);
    dropReq(2);
    waitDone(10, 1'b0);
    checkOutput("t4_then_3", 32'(done), 32'h8);
    dropReq(3);
    repeat (2) @(negedge clk);
    checkOutput("t4_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] irq and request drop together");
    pushGrant(1, 32'd30, 1'b1);
    applyStimulus(1, 32'd30);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (tmr_irq) found = 1'b1;
    end
    checkOutput("t5_irq_seen", 32'(found), 32'd1);
    req[1] = 1'b0;
    waitDone(10, 1'b0);
    checkOutput("t5_done_vec", 32'(done), 32'h2);
    repeat (2) @(negedge clk);
    checkOutput("t5_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset during WR_PH and WAIT_IRQ");
    pushGrant(0, 32'd50, 1'b1);
    applyStimulus(0, 32'd50);
    waitWrite(3'd3, 5);
    reset = 1'b1; req = '0; exp_q.delete();
    @(negedge clk); #1;
    checkResetValues();
    reset = 1'b0;
    pushGrant(2, 32'd100, 1'b1);
    applyStimulus(2, 32'd100);
    waitWrite(3'd1, 5);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1; req = '0; exp_q.delete();
    @(negedge clk); #1;
    checkResetValues();
    reset = 1'b0;
    pushGrant(3, 32'd10, 1'b1);
    applyStimulus(3, 32'd10);
    @(negedge clk); #1;
    checkOutput("t6_active_id", 32'(active_id), 32'd3);
    waitDone(100, 1'b1);
    checkOutput("t6_done_vec", 32'(done), 32'h8);
    dropReq(3);
    repeat (2) @(negedge clk);
    checkOutput("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
# timer_sched

Time-shares one interval-timer slave (16-bit Avalon-MM register map: status/control/period_l/period_h) between N hardware requesters. Each requester asks for a one-shot delay of a given cycle count. The block arbitrates round-robin, programs the timer through a zero-wait-state Avalon master port, waits for the timer irq, clears it, and pulses completion to the winner. It sits between the camera-control logic and the system timer, replacing software-driven timer programming.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `req` in N_REQ: level request per requester; held until `done` or until withdrawn.
- `req_period` in 32*N_REQ: delay in timer ticks; slice i is `[32*i+31:32*i]`.
- `done` out N_REQ: one-cycle completion pulse, one-hot.
- `busy` out 1: high in every state except IDLE.
- `active_id` out 3: index of the requester being served; holds its last value in IDLE.
- `tmr_address` out 3: timer register address.
- `tmr_chipselect` out 1: timer select.
- `tmr_write_n` out 1: active-low write strobe.
- `tmr_writedata` out 16: timer write data.
- `tmr_irq` in 1: timer interrupt (level, registered in the timer).

## Operation
- Timer map: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h. A period write stops and reloads the counter.
- Master port is write-only. Each write lasts exactly one cycle with `tmr_chipselect`=1 and `tmr_write_n`=0. The timer slave has zero wait states.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTL, WAIT_IRQ, WR_STOP, WR_STAT, DONE.
- **IDLE:** if any `req` is high, the round-robin winner is chosen this cycle. Its id goes to `active_id` and its period to a 32-bit latch.
  - Latched period 0 -> next state is DONE. No timer access, because period 0 produces no timeout edge on the timer.
  - Otherwise -> next state is WR_PL.
- **WR_PL:** addr 2, data period[15:0]. Next state WR_PH.
- **WR_PH:** addr 3, data period[31:16]. Next state WR_CTL.
- **WR_CTL:** addr 1, data 16'h0005 (ITO + START, one-shot). Next state WAIT_IRQ.
- **WAIT_IRQ** (no bus activity):
  - `tmr_irq`=1 -> WR_STAT, then completion.
  - `req[active_id]`=0 with `tmr_irq`=0 -> WR_STOP (abort).
  - `tmr_irq`=1 and `req[active_id]`=0 together -> irq wins. It completes normally and `done` still pulses.
- **WR_STOP:** addr 1, data 16'h0008. Next state WR_STAT.
- **WR_STAT:** addr 0, data 0. Next state is DONE on the completion path, IDLE on the abort path.
- **DONE:** `done[active_id]`=1 for one cycle, round-robin pointer becomes `active_id`+1 (mod N_REQ). Next state IDLE.
- **Round robin:** search starts at the pointer and wraps. The pointer resets to 0 and advances only on DONE. An aborted requester keeps its priority.
- **Latching:** `req_period` is sampled only at grant. Later changes to it are ignored.
- **Bus idle values:** `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- **Reset in any state:** return to IDLE next edge, bus idle, no `done`. The timer is not stopped; a stale irq left by reset is cleared by the next WR_STAT.

## Timing
- All outputs are decoded from registered state and latches; there is no combinational path from `req` or `tmr_irq` to any output.
- Reset values: `done`=0, `busy`=0, `active_id`=0, `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- Grant latency: `req` seen in IDLE at cycle 0 -> WR_PL write at cycle 1, WR_PH at 2, WR_CTL at 3, WAIT_IRQ from cycle 4.
- Completion latency: `tmr_irq` first high at cycle k -> WR_STAT write at k+1, `done` at k+2, IDLE at k+3. The next grant is decided at k+3.
- Period-0 request: grant at cycle 0, `done` at cycle 1.
- Timer irq arrives about P+2 cycles after WR_CTL. The bench allows +/-3 cycles.

## Structure
- Package `timer_sched_pkg` holds:
  - register address constants: ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIOD_L=2, ADDR_PERIOD_H=3;
  - control words: CTL_START_ITO=16'h0005, CTL_STOP=16'h0008;
  - the state enum.
- One sub-module, `rr_arbiter`, parameterised by N_REQ. Inputs: request vector, pointer. Outputs: grant valid, grant index.
- The top level holds the FSM, the period latch, and output decode.

## Test plan
1. Single request: req[1]=1, period 100 -> writes (2,0x0064), (3,0x0000), (1,0x0005) on consecutive cycles. After the irq, one write (0,0) then `done`=4'b0010. `busy` stays high from grant through DONE.
2. All four requesting continuously, period 20 -> grants in order 0,1,2,3,0. Exactly one `done` per grant.
3. Period 0x0001_2345 -> period_l write 0x2345, period_h write 0x0001. Period 0 -> `done` one cycle after grant with no `tmr_chipselect`.
4. Abort: drop req[2] mid-WAIT_IRQ -> writes (1,0x0008) then (0,0), no `done`. The next grant goes to requester 2 again if it re-requests.
5. irq and req drop in the same cycle -> completion path; `done[id]` pulses.
6. Reset asserted during WR_PH and during WAIT_IRQ -> next cycle all outputs at reset values; after release a new request is served normally.
